// File: rtl/argon_pkg.sv
// Shared types and helpers for the Argon load/store unit: op encodings, FSM states,
// memory mask encodings and op decode functions.
package argon_pkg;

  typedef enum logic [2:0] {
    LSU_LB  = 3'd0,
    LSU_LH  = 3'd1,
    LSU_LW  = 3'd2,
    LSU_LBU = 3'd3,
    LSU_LHU = 3'd4,
    LSU_SB  = 3'd5,
    LSU_SH  = 3'd6,
    LSU_SW  = 3'd7
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] WR_MASK_NONE = 2'b00;
  localparam logic [1:0] WR_MASK_BYTE = 2'b01;
  localparam logic [1:0] WR_MASK_HALF = 2'b10;
  localparam logic [1:0] WR_MASK_WORD = 2'b11;

  localparam logic [2:0] RD_MASK_NONE = 3'b000;
  localparam logic [2:0] RD_MASK_BYTE = 3'b001;
  localparam logic [2:0] RD_MASK_HALF = 3'b010;
  localparam logic [2:0] RD_MASK_WORD = 3'b011;

  function automatic logic op_is_store(input lsu_op_e op);
    return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
  endfunction

  function automatic logic op_is_signed(input lsu_op_e op);
    return (op == LSU_LB) || (op == LSU_LH);
  endfunction

  function automatic logic [1:0] op_size(input lsu_op_e op);
    case (op)
      LSU_LB, LSU_LBU, LSU_SB: return SIZE_BYTE;
      LSU_LH, LSU_LHU, LSU_SH: return SIZE_HALF;
      default:                 return SIZE_WORD;
    endcase
  endfunction

  function automatic logic [1:0] op_wr_mask(input lsu_op_e op);
    if (!op_is_store(op)) return WR_MASK_NONE;
    case (op_size(op))
      SIZE_BYTE: return WR_MASK_BYTE;
      SIZE_HALF: return WR_MASK_HALF;
      default:   return WR_MASK_WORD;
    endcase
  endfunction

  function automatic logic [2:0] op_rd_mask(input lsu_op_e op);
    if (op_is_store(op)) return RD_MASK_NONE;
    case (op_size(op))
      SIZE_BYTE: return RD_MASK_BYTE;
      SIZE_HALF: return RD_MASK_HALF;
      default:   return RD_MASK_WORD;
    endcase
  endfunction

  function automatic logic op_misaligned(input lsu_op_e op, input logic [1:0] addr_lo);
    case (op_size(op))
      SIZE_HALF: return addr_lo[0];
      SIZE_WORD: return |addr_lo;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_extend.sv
// Combinational size/sign extension of low-justified load data from Memory.
module lsu_load_extend
  import argon_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  lsu_op_e         i_op,
  input  logic [XLEN-1:0] i_rd_data,
  output logic [XLEN-1:0] o_ext_data
);

  always_comb begin
    o_ext_data = i_rd_data;
    case (i_op)
      LSU_LB:  o_ext_data = {{(XLEN-8){i_rd_data[7]}}, i_rd_data[7:0]};
      LSU_LH:  o_ext_data = {{(XLEN-16){i_rd_data[15]}}, i_rd_data[15:0]};
      LSU_LBU: o_ext_data = {{(XLEN-8){1'b0}}, i_rd_data[7:0]};
      LSU_LHU: o_ext_data = {{(XLEN-16){1'b0}}, i_rd_data[15:0]};
      default: o_ext_data = i_rd_data;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Argon memory-access stage: one load/store in flight, 1-cycle read latency Memory.
// Optional ARGON_LSU_MISALIGN_TRAP_EN traps misaligned requests before they reach Memory.
module load_store_unit
  import argon_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_halt,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [2:0]      i_req_op,
  input  logic [XLEN-1:0] i_req_addr,
  input  logic [XLEN-1:0] i_req_wdata,
  output logic [XLEN-1:0] o_mem_address,
  output logic [XLEN-1:0] o_mem_wr_data,
  output logic [1:0]      o_mem_wr_mask,
  output logic [2:0]      o_mem_rd_mask,
  input  logic [XLEN-1:0] i_mem_rd_data,
  input  logic            i_mem_err_misaligned,
  input  logic            i_mem_err_rd_mask,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic [1:0]      o_rsp_err
);

  lsu_state_e      state_q, state_d;
  lsu_op_e         op_q, op_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [1:0]      wr_mask_q, wr_mask_d;
  logic [2:0]      rd_mask_q, rd_mask_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]      rsp_err_q, rsp_err_d;

  lsu_op_e         req_op;
  logic            req_fire;
  logic            trap_hit;
  logic [1:0]      mem_err;
  logic [XLEN-1:0] ext_data;

  assign req_op   = lsu_op_e'(i_req_op);
  assign req_fire = i_req_valid && o_req_ready;
  assign mem_err  = {i_mem_err_rd_mask, i_mem_err_misaligned};

`ifdef ARGON_LSU_MISALIGN_TRAP_EN
  assign trap_hit = op_misaligned(req_op, i_req_addr[1:0]);
`else
  assign trap_hit = 1'b0;
`endif

  lsu_load_extend #(.XLEN(XLEN)) u_load_extend (
    .i_op       (op_q),
    .i_rd_data  (i_mem_rd_data),
    .o_ext_data (ext_data)
  );

  // Masks are registered so they are high only for the ACCESS cycle and drop on async reset.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_mask_d  = WR_MASK_NONE;
    rd_mask_d  = RD_MASK_NONE;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_fire) begin
          op_d    = req_op;
          addr_d  = i_req_addr;
          wdata_d = i_req_wdata;
          if (trap_hit) begin
            state_d    = ST_RESP;
            rsp_data_d = '0;
            rsp_err_d  = 2'b01;
          end else begin
            state_d   = ST_ACCESS;
            wr_mask_d = op_wr_mask(req_op);
            rd_mask_d = op_rd_mask(req_op);
          end
        end
      end
      ST_ACCESS: begin
        if (op_is_store(op_q)) begin
          state_d    = ST_RESP;
          rsp_data_d = '0;
          rsp_err_d  = mem_err;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        state_d    = ST_RESP;
        rsp_err_d  = mem_err;
        rsp_data_d = (|mem_err) ? '0 : ext_data;
      end
      ST_RESP: begin
        if (i_rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ST_IDLE;
      op_q       <= LSU_LW;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_mask_q  <= WR_MASK_NONE;
      rd_mask_q  <= RD_MASK_NONE;
      rsp_data_q <= '0;
      rsp_err_q  <= 2'b00;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_mask_q  <= wr_mask_d;
      rd_mask_q  <= rd_mask_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Ready is gated by reset so execute never sees a handshake while the unit is held in reset.
  assign o_req_ready   = (state_q == ST_IDLE) && !i_halt && i_reset_n;
  assign o_rsp_valid   = (state_q == ST_RESP);
  assign o_rsp_data    = rsp_data_q;
  assign o_rsp_err     = rsp_err_q;
  assign o_mem_address = addr_q;
  assign o_mem_wr_data = wdata_q;
  assign o_mem_wr_mask = wr_mask_q;
  assign o_mem_rd_mask = rd_mask_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table plus scoreboard, and hand-written
// sequences for backpressure, halt and mid-transaction reset.
module tb_load_store_unit;
  import argon_pkg::*;

  logic        i_clk;
  logic        i_reset_n;
  logic        i_halt;
  logic        i_req_valid;
  logic        o_req_ready;
  logic [2:0]  i_req_op;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [31:0] o_mem_address;
  logic [31:0] o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] i_mem_rd_data;
  logic        i_mem_err_misaligned;
  logic        i_mem_err_rd_mask;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_data;
  logic [1:0]  o_rsp_err;

  typedef struct {
    lsu_op_e     op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err_mis;
    logic        err_rdm;
    logic [31:0] exp_data;
    logic [1:0]  exp_err;
    logic [1:0]  exp_wr;
    logic [2:0]  exp_rd;
    int          exp_lat;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  err;
  } rsp_t;

  vec_t  vecs[10];
  rsp_t  sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;

  logic [31:0] cur_rdata;
  logic        cur_err_mis;
  logic        cur_err_rdm;
  logic        rd_pending;

  load_store_unit #(.XLEN(32)) dut (
    .i_clk                (i_clk),
    .i_reset_n            (i_reset_n),
    .i_halt               (i_halt),
    .i_req_valid          (i_req_valid),
    .o_req_ready          (o_req_ready),
    .i_req_op             (i_req_op),
    .i_req_addr           (i_req_addr),
    .i_req_wdata          (i_req_wdata),
    .o_mem_address        (o_mem_address),
    .o_mem_wr_data        (o_mem_wr_data),
    .o_mem_wr_mask        (o_mem_wr_mask),
    .o_mem_rd_mask        (o_mem_rd_mask),
    .i_mem_rd_data        (i_mem_rd_data),
    .i_mem_err_misaligned (i_mem_err_misaligned),
    .i_mem_err_rd_mask    (i_mem_err_rd_mask),
    .o_rsp_valid          (o_rsp_valid),
    .i_rsp_ready          (i_rsp_ready),
    .o_rsp_data           (o_rsp_data),
    .o_rsp_err            (o_rsp_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Memory model: read data and errors are only meaningful in the cycle the DUT should sample them.
  always @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) rd_pending <= 1'b0;
    else            rd_pending <= (o_mem_rd_mask != 3'b000);
  end

  assign i_mem_rd_data        = rd_pending ? cur_rdata : 32'hA5A5_A5A5;
  assign i_mem_err_misaligned = (rd_pending || o_mem_wr_mask != 2'b00) ? cur_err_mis : 1'b0;
  assign i_mem_err_rd_mask    = (rd_pending || o_mem_wr_mask != 2'b00) ? cur_err_rdm : 1'b0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, input int stall, input logic halt_mid);
    int   lat;
    int   wr_cnt;
    int   rd_cnt;
    rsp_t exp;
    @(negedge i_clk);
    i_req_valid = 1'b1;
    i_req_op    = v.op;
    i_req_addr  = v.addr;
    i_req_wdata = v.wdata;
    cur_rdata   = v.rdata;
    cur_err_mis = v.err_mis;
    cur_err_rdm = v.err_rdm;
    i_rsp_ready = (stall == 0);
    check_output("req_ready_idle", {31'd0, o_req_ready}, 32'd1);
    exp.data = v.exp_data;
    exp.err  = v.exp_err;
    sb_q.push_back(exp);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    if (halt_mid) i_halt = 1'b1;
    lat = 0; wr_cnt = 0; rd_cnt = 0;
    do begin
      @(negedge i_clk);
      lat++;
      if (o_mem_wr_mask != 2'b00) begin
        wr_cnt++;
        check_output("wr_mask", {30'd0, o_mem_wr_mask}, {30'd0, v.exp_wr});
        check_output("wr_address", o_mem_address, v.addr);
        check_output("wr_data", o_mem_wr_data, v.wdata);
      end
      if (o_mem_rd_mask != 3'b000) begin
        rd_cnt++;
        check_output("rd_mask", {29'd0, o_mem_rd_mask}, {29'd0, v.exp_rd});
        check_output("rd_address", o_mem_address, v.addr);
      end
    end while (!o_rsp_valid && lat < 8);
    check_output("rsp_latency", lat, v.exp_lat);
    check_output("wr_mask_cycles", wr_cnt, (v.exp_wr != 2'b00) ? 1 : 0);
    check_output("rd_mask_cycles", rd_cnt, (v.exp_rd != 3'b000) ? 1 : 0);
    check_output("req_ready_busy", {31'd0, o_req_ready}, 32'd0);
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    check_output("rsp_data", o_rsp_data, exp.data);
    check_output("rsp_err", {30'd0, o_rsp_err}, {30'd0, exp.err});
    for (int i = 0; i < stall; i++) begin
      @(negedge i_clk);
      check_output("stall_valid", {31'd0, o_rsp_valid}, 32'd1);
      check_output("stall_data", o_rsp_data, exp.data);
      check_output("stall_req_ready", {31'd0, o_req_ready}, 32'd0);
    end
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_halt = 1'b0;
    @(negedge i_clk);
    check_output("rsp_valid_drop", {31'd0, o_rsp_valid}, 32'd0);
    check_output("req_ready_back", {31'd0, o_req_ready}, 32'd1);
  endtask

  initial begin
    vec_t bp;
    logic saw_rsp;
    vecs[0] = '{LSU_LB,  32'h100, 32'h0,         32'h0000_0080, 1'b0, 1'b0, 32'hFFFF_FF80, 2'b00, WR_MASK_NONE, RD_MASK_BYTE, 3};
    vecs[1] = '{LSU_LHU, 32'h102, 32'h0,         32'h0000_8001, 1'b0, 1'b0, 32'h0000_8001, 2'b00, WR_MASK_NONE, RD_MASK_HALF, 3};
    vecs[2] = '{LSU_SW,  32'h200, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0, 32'h0,         2'b00, WR_MASK_WORD, RD_MASK_NONE, 2};
    vecs[3] = '{LSU_LH,  32'h104, 32'h0,         32'h0000_8001, 1'b0, 1'b0, 32'hFFFF_8001, 2'b00, WR_MASK_NONE, RD_MASK_HALF, 3};
    vecs[4] = '{LSU_LBU, 32'h105, 32'h0,         32'h1234_56F0, 1'b0, 1'b0, 32'h0000_00F0, 2'b00, WR_MASK_NONE, RD_MASK_BYTE, 3};
    vecs[5] = '{LSU_LW,  32'h108, 32'h0,         32'hCAFE_F00D, 1'b0, 1'b0, 32'hCAFE_F00D, 2'b00, WR_MASK_NONE, RD_MASK_WORD, 3};
    vecs[6] = '{LSU_SB,  32'h10A, 32'h0000_0055, 32'h0,         1'b0, 1'b0, 32'h0,         2'b00, WR_MASK_BYTE, RD_MASK_NONE, 2};
    vecs[7] = '{LSU_SH,  32'h10C, 32'h0000_1234, 32'h0,         1'b0, 1'b0, 32'h0,         2'b00, WR_MASK_HALF, RD_MASK_NONE, 2};
`ifdef ARGON_LSU_MISALIGN_TRAP_EN
    vecs[8] = '{LSU_LW,  32'h203, 32'h0,         32'h0000_1234, 1'b1, 1'b0, 32'h0,         2'b01, WR_MASK_NONE, RD_MASK_NONE, 1};
`else
    vecs[8] = '{LSU_LW,  32'h203, 32'h0,         32'h0000_1234, 1'b1, 1'b0, 32'h0,         2'b01, WR_MASK_NONE, RD_MASK_WORD, 3};
`endif
    vecs[9] = '{LSU_LB,  32'h110, 32'h0,         32'h0000_007F, 1'b0, 1'b1, 32'h0,         2'b10, WR_MASK_NONE, RD_MASK_BYTE, 3};

    i_reset_n   = 1'b0;
    i_halt      = 1'b0;
    i_req_valid = 1'b0;
    i_req_op    = 3'd0;
    i_req_addr  = 32'd0;
    i_req_wdata = 32'd0;
    i_rsp_ready = 1'b1;
    cur_rdata   = 32'd0;
    cur_err_mis = 1'b0;
    cur_err_rdm = 1'b0;

    repeat (2) @(negedge i_clk);
    i_req_valid = 1'b1;
    #1;
    check_output("reset_req_ready", {31'd0, o_req_ready}, 32'd0);
    check_output("reset_rsp_valid", {31'd0, o_rsp_valid}, 32'd0);
    check_output("reset_rsp_data", o_rsp_data, 32'd0);
    check_output("reset_rsp_err", {30'd0, o_rsp_err}, 32'd0);
    check_output("reset_masks", {27'd0, o_mem_wr_mask, o_mem_rd_mask}, 32'd0);
    check_output("reset_address", o_mem_address, 32'd0);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    i_reset_n = 1'b1;

    for (int i = 0; i < 10; i++) apply_stimulus(vecs[i], 0, 1'b0);

    $display("[TB] backpressure with halt raised mid-transaction");
    bp = '{LSU_LW, 32'h300, 32'h0, 32'h1122_3344, 1'b0, 1'b0, 32'h1122_3344, 2'b00, WR_MASK_NONE, RD_MASK_WORD, 3};
    apply_stimulus(bp, 5, 1'b1);

    $display("[TB] halt in IDLE blocks the handshake");
    @(negedge i_clk);
    i_halt      = 1'b1;
    i_req_valid = 1'b1;
    i_req_op    = LSU_LW;
    i_req_addr  = 32'h400;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check_output("halt_req_ready", {31'd0, o_req_ready}, 32'd0);
      check_output("halt_no_access", {29'd0, o_mem_rd_mask}, 32'd0);
      check_output("halt_no_rsp", {31'd0, o_rsp_valid}, 32'd0);
    end
    i_req_valid = 1'b0;
    i_halt      = 1'b0;
    @(negedge i_clk);
    check_output("halt_release_ready", {31'd0, o_req_ready}, 32'd1);

    $display("[TB] reset asserted during ACCESS");
    i_req_valid = 1'b1;
    i_req_op    = LSU_LW;
    i_req_addr  = 32'h404;
    cur_rdata   = 32'h7777_7777;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    check_output("rst_pre_mask", {29'd0, o_mem_rd_mask}, {29'd0, RD_MASK_WORD});
    #1;
    i_reset_n = 1'b0;
    #1;
    check_output("rst_async_rd_mask", {29'd0, o_mem_rd_mask}, 32'd0);
    check_output("rst_async_wr_mask", {30'd0, o_mem_wr_mask}, 32'd0);
    check_output("rst_req_ready", {31'd0, o_req_ready}, 32'd0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    saw_rsp = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      if (o_rsp_valid) saw_rsp = 1'b1;
    end
    check_output("rst_rsp_discarded", {31'd0, saw_rsp}, 32'd0);
    check_output("rst_ready_after", {31'd0, o_req_ready}, 32'd1);
    check_output("scoreboard_empty", sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
